teclado_captura: RTL and testbench

- Keypad capture stage that sits directly upstream of the cashier controller.
- Collects single-digit key strobes from the debounced keypad.
- In PIN mode it assembles a 4-digit packed-BCD PIN. In amount mode it assembles a decimal amount converted to 32-bit binary.
- Hands each result to the controller with a one-cycle strobe. Handles cancel, enter, invalid keys and inactivity timeout.

---
 rtl/cajero_pkg.sv | 11 +
 rtl/acumulador_decimal.sv | 8 +
 rtl/teclado_captura.sv | 117 +++++++++++
 tb/tb_teclado_captura.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/cajero_pkg.sv
// cajero_pkg: shared key codes, state encodings and sizes for the cashier keypad path
package cajero_pkg;
  localparam logic [3:0] TECLA_CANCELAR = 4'hA;
  localparam logic [3:0] TECLA_ENTER = 4'hC;
  localparam int PIN_DIGITOS = 4;
  typedef enum logic [2:0] {
    ST_IDLE    = 3'b001,
    ST_CAPTURA = 3'b010,
    ST_ENTREGA = 3'b100
  } estado_t;
endpackage

// File: rtl/acumulador_decimal.sv
// acumulador_decimal: combinational acc*10 + d using shifts, wrapping at 32 bits
module acumulador_decimal (
  input  logic [31:0] acc,
  input  logic [31:0] d,
  output logic [31:0] res
);
  assign res = (acc << 3) + (acc << 1) + d;
endmodule

// File: rtl/teclado_captura.sv
// teclado_captura: keypad capture of a 4-digit BCD PIN or a decimal amount, with cancel/enter/timeout
module teclado_captura
  import cajero_pkg::*;
#(
  parameter int MAX_DIGITOS = 9,
  parameter int TIMEOUT_CICLOS = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        habilitar,
  input  logic        modo_monto,
  input  logic        digito_stb,
  input  logic [3:0]  digito,
  output logic [15:0] pin,
  output logic        pin_stb,
  output logic [31:0] monto,
  output logic        monto_stb,
  output logic        entrada_invalida,
  output logic        cancelado,
  output logic        timeout,
  output logic        ocupado
);
  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
  estado_t state, state_n;
  logic modo, modo_n;
  logic [31:0] acc, acc_n, acc_dec, monto_n;
  logic [3:0] cnt, cnt_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [15:0] pin_n;
  logic pin_stb_n, monto_stb_n, inval_n, canc_n, to_n, ocupado_n;
  logic es_digito;
  assign es_digito = digito <= 4'd9;
  acumulador_decimal u_acc (.acc(acc), .d({28'b0, digito}), .res(acc_dec));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      modo <= 1'b0;
      acc <= '0;
      cnt <= '0;
      tmr <= '0;
      pin <= '0;
      monto <= '0;
      pin_stb <= 1'b0;
      monto_stb <= 1'b0;
      entrada_invalida <= 1'b0;
      cancelado <= 1'b0;
      timeout <= 1'b0;
      ocupado <= 1'b0;
    end else begin
      state <= state_n;
      modo <= modo_n;
      acc <= acc_n;
      cnt <= cnt_n;
      tmr <= tmr_n;
      pin <= pin_n;
      monto <= monto_n;
      pin_stb <= pin_stb_n;
      monto_stb <= monto_stb_n;
      entrada_invalida <= inval_n;
      cancelado <= canc_n;
      timeout <= to_n;
      ocupado <= ocupado_n;
    end
  end
  always_comb begin
    state_n = state;
    modo_n = modo;
    acc_n = acc;
    cnt_n = cnt;
    tmr_n = tmr;
    pin_n = pin;
    monto_n = monto;
    pin_stb_n = 1'b0;
    monto_stb_n = 1'b0;
    inval_n = 1'b0;
    canc_n = 1'b0;
    to_n = 1'b0;
    if (state == ST_IDLE) begin
      if (habilitar) begin
        state_n = ST_CAPTURA;
        modo_n = modo_monto;
        acc_n = '0;
        cnt_n = '0;
        tmr_n = '0;
      end
    end else if (state == ST_ENTREGA) begin
      state_n = ST_IDLE;
    end else if (digito_stb) begin
      tmr_n = '0;
      if (es_digito && !modo) begin
        acc_n = {16'b0, acc[11:0], digito};
        cnt_n = cnt + 4'd1;
        if (cnt == 4'(PIN_DIGITOS - 1)) begin
          pin_n = {acc[11:0], digito};
          pin_stb_n = 1'b1;
          state_n = ST_ENTREGA;
        end
      end else if (es_digito) begin
        if (cnt < 4'(MAX_DIGITOS)) begin
          acc_n = acc_dec;
          cnt_n = cnt + 4'd1;
        end else inval_n = 1'b1;
      end else if (digito == TECLA_ENTER && modo && cnt != 4'd0) begin
        monto_n = acc;
        monto_stb_n = 1'b1;
        state_n = ST_ENTREGA;
      end else if (digito == TECLA_CANCELAR) begin
        canc_n = 1'b1;
        state_n = ST_IDLE;
      end else inval_n = 1'b1;
    end else if (tmr == TW'(TIMEOUT_CICLOS - 1)) begin
      to_n = 1'b1;
      state_n = ST_IDLE;
    end else tmr_n = tmr + 1'b1;
    ocupado_n = state_n != ST_IDLE;
  end
endmodule

// File: tb/tb_teclado_captura.sv
// tb_teclado_captura: directed-vector bench for teclado_captura with pulse counters
module tb_teclado_captura;
  logic clk = 1'b0, rst = 1'b1, habilitar = 1'b0, modo_monto = 1'b0, digito_stb = 1'b0;
  logic [3:0] digito = 4'd0;
  logic [15:0] pin;
  logic [31:0] monto;
  logic pin_stb, monto_stb, entrada_invalida, cancelado, timeout, ocupado;
  int errors = 0, checks = 0, n = 0;
  int n_pin = 0, n_monto = 0, n_inv = 0, n_canc = 0, n_to = 0, n_multi = 0;
  int b_pin, b_monto, b_inv, b_canc, b_to;

  teclado_captura #(.MAX_DIGITOS(9), .TIMEOUT_CICLOS(20)) dut (
    .clk(clk), .rst(rst), .habilitar(habilitar), .modo_monto(modo_monto),
    .digito_stb(digito_stb), .digito(digito), .pin(pin), .pin_stb(pin_stb),
    .monto(monto), .monto_stb(monto_stb), .entrada_invalida(entrada_invalida),
    .cancelado(cancelado), .timeout(timeout), .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    n_pin += int'(pin_stb);
    n_monto += int'(monto_stb);
    n_inv += int'(entrada_invalida);
    n_canc += int'(cancelado);
    n_to += int'(timeout);
    if ($countones({pin_stb, monto_stb, entrada_invalida, cancelado, timeout}) > 1) n_multi++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    digito_stb = 1'b1;
    digito = d;
    tick();
    digito_stb = 1'b0;
  endtask

  task automatic key_gap(input logic [3:0] d);
    key(d);
    tick();
    tick();
  endtask

  task automatic start(input logic m);
    habilitar = 1'b1;
    modo_monto = m;
    tick();
    habilitar = 1'b0;
  endtask

  task automatic snap();
    b_pin = n_pin; b_monto = n_monto; b_inv = n_inv; b_canc = n_canc; b_to = n_to;
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    check("reset_outs", {pin, monto, pin_stb, monto_stb, entrada_invalida, cancelado, timeout, ocupado}, '0);
    check("reset_hi", 32'(pin), 32'h0);

    snap();
    start(1'b0);
    check("pin_busy", 32'(ocupado), 1);
    key_gap(4'd1); key_gap(4'd2); key_gap(4'd3);
    key(4'd4);
    check("pin_stb_hi", 32'(pin_stb), 1);
    check("pin_val", 32'(pin), 32'h1234);
    check("pin_entrega_busy", 32'(ocupado), 1);
    tick();
    check("pin_stb_lo", 32'(pin_stb), 0);
    check("pin_idle", 32'(ocupado), 0);
    check("pin_pulses", n_pin - b_pin, 1);

    snap();
    start(1'b1);
    key(4'd2); key(4'd5); key(4'd0); key(4'd0); key(4'hC);
    check("monto_stb_hi", 32'(monto_stb), 1);
    check("monto_2500", monto, 32'd2500);
    tick();
    check("monto_stb_lo", 32'(monto_stb), 0);
    start(1'b1);
    repeat (9) key(4'd9);
    key(4'd7);
    check("overflow_inv", 32'(entrada_invalida), 1);
    key(4'hC);
    check("monto_max", monto, 32'd999999999);
    tick();
    check("monto_pulses", n_monto - b_monto, 2);
    check("overflow_inv_pulses", n_inv - b_inv, 1);

    snap();
    start(1'b1);
    key(4'd4);
    key(4'hB);
    check("inval_B", 32'(entrada_invalida), 1);
    key(4'hA);
    check("cancel_hi", 32'(cancelado), 1);
    check("cancel_idle", 32'(ocupado), 0);
    tick();
    check("cancel_monto_kept", monto, 32'd999999999);
    check("cancel_pulses", (n_canc - b_canc) * 16 + (n_inv - b_inv) * 4 + (n_monto - b_monto), 32'h14);

    snap();
    start(1'b0);
    key(4'd1); key(4'd2);
    n = 0;
    while (!timeout && n < 40) begin
      tick();
      n++;
    end
    check("timeout_delay", n, 20);
    check("timeout_idle", 32'(ocupado), 0);
    tick();
    check("timeout_pulses", n_to - b_to, 1);

    snap();
    start(1'b0);
    key(4'd1); key(4'd2);
    repeat (19) tick();
    key(4'd3);
    check("expiry_strobe_no_to", 32'(timeout), 0);
    key(4'd4);
    check("expiry_pin", 32'(pin), 32'h1234);
    check("expiry_pin_stb", 32'(pin_stb), 1);
    tick();
    check("expiry_to_pulses", n_to - b_to, 0);

    start(1'b0);
    key(4'd9); key(4'd9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_outs", {pin, monto, pin_stb, monto_stb, entrada_invalida, cancelado, timeout, ocupado}, '0);
    check("midrst_monto", monto, 0);
    start(1'b0);
    key(4'd5); key(4'd6); key(4'd7); key(4'd8);
    check("midrst_pin", 32'(pin), 32'h5678);
    tick();

    snap();
    key(4'd3);
    key(4'hC);
    check("idle_strobe_busy", 32'(ocupado), 0);
    start(1'b0);
    key(4'd1);
    start(1'b1);
    key(4'hC);
    check("pin_enter_inv", 32'(entrada_invalida), 1);
    check("pin_enter_busy", 32'(ocupado), 1);
    key(4'd2); key(4'd3); key(4'd4);
    check("hab_ignored_pin", 32'(pin), 32'h1234);
    tick();
    start(1'b1);
    key(4'hC);
    check("empty_enter_inv", 32'(entrada_invalida), 1);
    check("empty_enter_busy", 32'(ocupado), 1);
    key(4'hA);
    tick();
    check("ignored_pulses", (n_inv - b_inv) * 256 + (n_pin - b_pin) * 16 + (n_monto - b_monto), 32'h210);
    check("exclusive_pulses", n_multi, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
